// File: rtl/i2s_pkg.sv
// Shared I2S transmit constants, frame type and word-select helper; combinational only, no handshake.
// Defining I2S_TX_LJ_EN selects left-justified word-select timing instead of standard I2S.
package i2s_pkg;

  localparam int I2S_WD        = 24;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_CLK_DIV   = 16;

  typedef struct packed {
    logic [I2S_WD-1:0] left;
    logic [I2S_WD-1:0] right;
  } i2s_frame_t;

  // Word-select level while slot index k is on the wire.
  function automatic logic lrclk_at(int k, int slot_bits);
`ifdef I2S_TX_LJ_EN
    return (k >= slot_bits);
`else
    return (k >= slot_bits - 1) && (k <= 2 * slot_bits - 2);
`endif
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider: bclk toggles every CLK_DIV clocks; fall_evt is high in the cycle whose
// closing edge drives bclk 1->0. Free-running, no backpressure.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  output logic bclk,
  output logic fall_evt
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          tc;

  assign tc       = (div_cnt == DW'(CLK_DIV - 1));
  assign fall_evt = tc && bclk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-frame holding register, data launched on bclk fall, frame load every 2*SLOT_BITS bclks.
// Backpressure: ready_out low while a frame is held; empty at load mutes the frame and pulses underrun (I2S_TX_LJ_EN = LJ mode).
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int WD_IN     = I2S_WD,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int CLK_DIV   = I2S_CLK_DIV
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WD_IN-1:0] left_in,
  input  logic [WD_IN-1:0] right_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CW         = $clog2(FRAME_BITS);

  typedef struct packed {
    logic [WD_IN-1:0] left;
    logic [WD_IN-1:0] right;
  } frame_t;

  logic                  full;
  frame_t                hold;
  logic                  fall_evt;
  logic                  accept;
  logic                  wrap;
  logic                  load;
  logic [CW-1:0]         bit_cnt;
  logic [CW-1:0]         bit_nxt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] load_val;

  i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .reset_n  (reset_n),
    .bclk     (bclk),
    .fall_evt (fall_evt)
  );

  assign ready_out = !full;
  assign accept    = valid_in && !full;
  assign wrap      = (bit_cnt == CW'(FRAME_BITS - 1));
  assign bit_nxt   = wrap ? '0 : bit_cnt + CW'(1);
  assign load      = fall_evt && wrap;

  // Whole frame as it appears on the wire: each sample MSB-aligned in its slot, zero padded.
  always_comb begin
    load_val = '0;
    if (full) begin
      load_val[FRAME_BITS-1 -: WD_IN] = hold.left;
      load_val[SLOT_BITS-1  -: WD_IN] = hold.right;
    end
  end

  // A load with an empty register has priority over nothing; an accept on that edge stays held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      hold <= '0;
    end else if (load && full) begin
      full <= 1'b0;
    end else if (accept) begin
      full       <= 1'b1;
      hold.left  <= left_in;
      hold.right <= right_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= CW'(FRAME_BITS - 1);
      shreg    <= '0;
      sdata    <= 1'b0;
      lrclk    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= load && !full;
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        lrclk   <= lrclk_at(int'(bit_nxt), SLOT_BITS);
        if (wrap) begin
          sdata <= load_val[FRAME_BITS-1];
          shreg <= {load_val[FRAME_BITS-2:0], 1'b0};
        end else begin
          sdata <= shreg[FRAME_BITS-1];
          shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S serial transmitter for the audio equalizer output path. It accepts one parallel stereo frame of signed samples from the FIR filter bank through a valid/ready handshake. It generates BCLK and LRCLK from the system clock and shifts the samples out MSB-first on SDATA to the DAC. It is the output-side counterpart of the I2S receiver that feeds the filters.

## Interface
- `WD_IN`, 24: sample width per channel; requires `WD_IN <= SLOT_BITS`.
- `SLOT_BITS`, 32: BCLK periods per channel slot; frame = 2*SLOT_BITS.
- `CLK_DIV`, 16: system clocks per BCLK half-period; requires `CLK_DIV >= 2`.
- Ports:
  - `clk` input 1: system clock, 100 MHz.
  - `reset_n` input 1: asynchronous active-low reset.
  - `left_in` input WD_IN: left sample, two's complement.
  - `right_in` input WD_IN: right sample, two's complement.
  - `valid_in` input 1: frame on `left_in`/`right_in` is valid.
  - `ready_out` output 1: holding register is empty.
  - `bclk` output 1: bit clock.
  - `lrclk` output 1: word select; 0 = left, 1 = right.
  - `sdata` output 1: serial data.
  - `underrun` output 1: one-cycle pulse when a frame boundary finds no data.

## Operation
- Holding register: one stereo frame plus a `full` flag.
  - `ready_out = !full`.
  - A frame is accepted on the rising `clk` edge with `valid_in && ready_out`, which sets `full`.
- Divider: `div_cnt` counts 0..CLK_DIV-1. At terminal count `bclk` toggles and `div_cnt` wraps to 0.
- Fall event: the edge where `bclk` toggles 1->0. On this same edge:
  - `bit_cnt` advances, modulo 2*SLOT_BITS.
  - `sdata` and `lrclk` update.
- Frame load: the fall event where `bit_cnt` wraps to 0.
  - If `full` is set: the shift registers load from the holding register and `full` clears.
  - If `full` is clear: the shift registers load zero (mute) and `underrun` pulses for one cycle.
  - `full` is sampled before the edge. An accept in the same cycle as the load stays in the holding register for the next frame and does not prevent the underrun.
- Bit mapping for slot index k = `bit_cnt`:
  - Left slot, k < WD_IN: `sdata` = left bit WD_IN-1-k.
  - Right slot, SLOT_BITS <= k < SLOT_BITS+WD_IN: `sdata` = right bit WD_IN-1-(k-SLOT_BITS).
  - All other slot positions: `sdata` = 0.
- `lrclk` (I2S mode): 1 for k in [SLOT_BITS-1, 2*SLOT_BITS-2], else 0. Its edge leads the MSB by one BCLK.
- Reset mid-frame: all state clears asynchronously and any held frame is discarded. After release, operation restarts as from power-up.

## Timing
- Reset values: `bclk`=0, `lrclk`=0, `sdata`=0, `underrun`=0, `ready_out`=1.
- Reset values of internal state: `div_cnt`=0, `bit_cnt`=2*SLOT_BITS-1, `full`=0.
- `bclk` rises CLK_DIV cycles after reset release and has its first fall at 2*CLK_DIV. That first fall is a frame load.
- Data launches on the BCLK fall and is stable around the BCLK rise for CLK_DIV cycles.
- Frame period: 4*SLOT_BITS*CLK_DIV clocks, which is 2048 by default (48.83 kHz at 100 MHz).
- `ready_out` reasserts on the load edge. The producer then has one full frame period to supply the next frame.

## Configuration
- `I2S_TX_LJ_EN` defined: left-justified format. `lrclk` is 1 for k in [SLOT_BITS, 2*SLOT_BITS-1], so it changes on the same fall event as the MSB. `sdata` mapping is unchanged.
- `I2S_TX_LJ_EN` undefined: standard I2S with the one-BCLK `lrclk` lead described above.

## Structure
- Package `i2s_pkg`:
  - Default constants `I2S_WD`, `I2S_SLOT_BITS`, `I2S_CLK_DIV`.
  - Typedef `i2s_frame_t` (packed struct: left, right).
  - Helper function returning the `lrclk` value for slot index k.
- Sub-module `i2s_clkgen`: divider and `bclk` generation; outputs `bclk` and a one-cycle `fall_evt` strobe.
- Top level: holding register, shift registers, `bit_cnt`, `lrclk`, `underrun`.

## Test plan
- Reset release, no input: first fall at clk 32. `underrun` pulses once per 2048 clocks, `sdata` stays 0, `lrclk` toggles every 1024 clocks.
- Accept left=24'hABCDEF, right=24'h123456 before the first fall: deserialized left slot = ABCDEF followed by 8 zeros; right slot = 123456; `ready_out` high again at clk 32.
- Continuous producer holding `valid_in` high with incrementing samples: no `underrun`, frames received in order, exactly one accept per 2048 clocks.
- Accept in the same cycle as a frame load with an empty holding register: `underrun` pulses and a muted frame is sent; the accepted frame is sent in the following frame.
- Assert `reset_n` low mid-right-slot: all outputs are at reset values immediately; after release the first fall occurs 32 clocks later and the held frame is gone.
- Build with `I2S_TX_LJ_EN`: `lrclk` edges coincide with the MSB fall event; data is identical to I2S mode.
